// File: rtl/morsecode_tx_ctrl.sv
// Morse character keyer: sends one character of 1..4 dot/dash symbols on led,
// timed by an external one-cycle tick strobe.
module morsecode_tx_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] code_len,
    input  logic [3:0] pattern,
    input  logic       tick,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] sym_left
);

    typedef enum logic [1:0] {IDLE, MARK, GAP, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_pattern;
    logic [2:0] r_sym_left;
    logic [1:0] r_unit_cnt;
    logic       r_led;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic       w_len_ok;
    logic [1:0] w_first_idx;
    logic [1:0] w_next_idx;
    logic       w_first_dash;
    logic       w_next_dash;

    assign w_len_ok     = (code_len != 3'd0) && (code_len <= 3'd4);
    // Symbols are sent MSB-first, so the symbol index is always count-1.
    assign w_first_idx  = code_len[1:0] - 2'd1;
    assign w_next_idx   = r_sym_left[1:0] - 2'd1;
    assign w_first_dash = pattern[w_first_idx];
    assign w_next_dash  = r_pattern[w_next_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pattern  <= 4'd0;
            r_sym_left <= 3'd0;
            r_unit_cnt <= 2'd0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_pattern  <= pattern;
                            r_sym_left <= code_len;
                            r_unit_cnt <= w_first_dash ? 2'd3 : 2'd1;
                            r_led      <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= MARK;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (tick) begin
                        if (r_unit_cnt > 2'd1) begin
                            r_unit_cnt <= r_unit_cnt - 2'd1;
                        end else if (r_sym_left == 3'd1) begin
                            // Last symbol: no trailing gap.
                            r_sym_left <= 3'd0;
                            r_unit_cnt <= 2'd0;
                            r_led      <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_sym_left <= r_sym_left - 3'd1;
                            r_unit_cnt <= 2'd1;
                            r_led      <= 1'b0;
                            r_state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        r_unit_cnt <= w_next_dash ? 2'd3 : 2'd1;
                        r_led      <= 1'b1;
                        r_state    <= MARK;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign led      = r_led;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign sym_left = r_sym_left;

endmodule

// File: tb/tb_morsecode_tx_ctrl.sv
// Directed bench for morsecode_tx_ctrl: a per-cycle vector table plus
// hand-written sequences for mid-character reset and a long tick stall.
module tb_morsecode_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] code_len;
    logic [3:0] pattern;
    logic       tick;
    logic       led, busy, done, err;
    logic [2:0] sym_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [2:0] len;
        logic [3:0] pat;
        logic       tick;
        logic [6:0] exp;   // {led, busy, done, err, sym_left}
    } vec_t;

    vec_t vq[$];

    morsecode_tx_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .code_len(code_len),
        .pattern(pattern), .tick(tick), .led(led), .busy(busy),
        .done(done), .err(err), .sym_left(sym_left)
    );

    always #5 clk = ~clk;

    task automatic add(input logic s, input logic [2:0] l, input logic [3:0] p, input logic t,
                       input logic eled, input logic ebusy, input logic edone, input logic eerr,
                       input logic [2:0] esym);
        vec_t v;
        v.start = s; v.len = l; v.pat = p; v.tick = t;
        v.exp = {eled, ebusy, edone, eerr, esym};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {led, busy, done, err, sym_left};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got led/busy/done/err/sym=%b/%b/%b/%b/%0d, want %b/%b/%b/%b/%0d",
                     name, act[6], act[5], act[4], act[3], act[2:0],
                     exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic cyc(input logic s, input logic [2:0] l, input logic [3:0] p, input logic t);
        start = s; code_len = l; pattern = p; tick = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; code_len = 3'd0; pattern = 4'd0; tick = 1'b0;

        // Rejects: illegal lengths give one-cycle err only
        add(1, 3'd0, 4'b0101, 0, 0, 0, 0, 1, 0);
        add(0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(1, 3'd5, 4'b1111, 0, 0, 0, 0, 1, 0);
        add(0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(1, 3'd7, 4'b0000, 1, 0, 0, 0, 1, 0);
        add(0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0);
        // "E" with tick held high; the start-cycle tick must not count
        add(1, 3'd1, 4'b0000, 1, 1, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 0, 1, 1, 0, 0);
        add(0, 3'd0, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 3'd0, 4'b0000, 1, 0, 0, 0, 0, 0);
        // "A" (dot, dash) with tick every 4th clk; starts ignored mid-dash
        add(1, 3'd2, 4'b0001, 0, 1, 1, 0, 0, 2);
        for (int k = 1; k <= 2; k++) add(0, 3'd0, 4'b0000, 0, 1, 1, 0, 0, 2);
        add(0, 3'd0, 4'b0000, 1, 0, 1, 0, 0, 1);
        for (int k = 4; k <= 6; k++) add(0, 3'd0, 4'b0000, 0, 0, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 1);
        for (int k = 8; k <= 18; k++)
            add((k == 9) || (k == 13), (k == 9) ? 3'd5 : 3'd1, 4'b0000, (k % 4) == 3,
                1, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 0, 1, 1, 0, 0);
        add(0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0);
        // "O" (three dashes) with tick every clk; starts in MARK/GAP/DONE ignored
        add(1, 3'd3, 4'b0111, 0, 1, 1, 0, 0, 3);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 3);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 3);
        add(1, 3'd0, 4'b0000, 1, 0, 1, 0, 0, 2);
        add(1, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 2);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 2);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 2);
        add(0, 3'd0, 4'b0000, 1, 0, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 1);
        add(0, 3'd0, 4'b0000, 1, 1, 1, 0, 0, 1);
        add(1, 3'd2, 4'b0000, 1, 0, 1, 1, 0, 0);
        add(1, 3'd0, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 7'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            cyc(vq[i].start, vq[i].len, vq[i].pat, vq[i].tick);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // Reset asserted during the 2nd tick of the first dash of "O"
        cyc(1, 3'd3, 4'b0111, 0);
        check("rst_seq_start", {1'b1, 1'b1, 1'b0, 1'b0, 3'd3});
        cyc(0, 3'd0, 4'b0000, 1);
        check("rst_seq_tick1", {1'b1, 1'b1, 1'b0, 1'b0, 3'd3});
        tick = 1'b1;
        #2 reset = 1'b1;
        #1 check("rst_async_clear", 7'd0);
        @(posedge clk);
        #1;
        check("rst_held", 7'd0);
        reset = 1'b0;
        cyc(0, 3'd0, 4'b0000, 0);
        check("rst_idle_after", 7'd0);
        cyc(1, 3'd1, 4'b0000, 1);
        check("post_rst_E_mark", {1'b1, 1'b1, 1'b0, 1'b0, 3'd1});
        cyc(0, 3'd0, 4'b0000, 1);
        check("post_rst_E_done", {1'b0, 1'b1, 1'b1, 1'b0, 3'd0});
        cyc(0, 3'd0, 4'b0000, 1);
        check("post_rst_E_idle", 7'd0);

        // Single dash: tick at start ignored, tick withheld 20 clk mid-mark
        cyc(1, 3'd1, 4'b0001, 1);
        check("stall_start", {1'b1, 1'b1, 1'b0, 1'b0, 3'd1});
        cyc(0, 3'd0, 4'b0000, 1);
        check("stall_tick1", {1'b1, 1'b1, 1'b0, 1'b0, 3'd1});
        for (int k = 0; k < 20; k++) begin
            cyc(0, 3'd0, 4'b0000, 0);
            check($sformatf("stall_hold%0d", k), {1'b1, 1'b1, 1'b0, 1'b0, 3'd1});
        end
        cyc(0, 3'd0, 4'b0000, 1);
        check("stall_tick2", {1'b1, 1'b1, 1'b0, 1'b0, 3'd1});
        cyc(0, 3'd0, 4'b0000, 1);
        check("stall_done", {1'b0, 1'b1, 1'b1, 1'b0, 3'd0});
        cyc(0, 3'd0, 4'b0000, 0);
        check("stall_idle", 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
